// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for an RV32I-subset CPU: IF/ID/EX/MEM/WB sequencing with combinational datapath controls.
// Optional build macro MEM_READY_EN adds a mem_ready handshake that stalls IF and MEM.
module multicycle_ctrl_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_bcond,
`ifdef MEM_READY_EN
    input  logic       mem_ready,
`endif
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       pc_write,
    output logic       pc_source,
    output logic       is_ecall,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0, S_ID = 4'd1, S_EX = 4'd2, S_MEM = 4'd3, S_WB = 4'd4,
        S_PC4 = 4'd5, S_BR = 4'd6, S_JAL = 4'd7, S_JR = 4'd8
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    state_t     state_r, next_state_s;
    logic       mem_done_s;
    logic [3:0] alu_op_s;
    logic       alu_src_a_s, i_or_d_s, mem_read_s, mem_write_s, ir_write_s;
    logic       mem_to_reg_s, reg_write_s, pc_write_s, pc_source_s, is_ecall_s;
    logic [1:0] alu_src_b_s;
    logic       is_r_s, is_load_s, is_store_s, is_jalr_s;

    function automatic logic [3:0] ex_alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  ex_alu_op = sub ? 4'b0001 : 4'b0000;
            3'b001:  ex_alu_op = 4'b1010;
            3'b100:  ex_alu_op = 4'b1000;
            3'b101:  ex_alu_op = 4'b1011;
            3'b110:  ex_alu_op = 4'b0101;
            3'b111:  ex_alu_op = 4'b0100;
            default: ex_alu_op = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] br_alu_op(input logic [2:0] f3);
        case (f3)
            3'b000:  br_alu_op = 4'b0000;
            3'b001:  br_alu_op = 4'b1010;
            3'b100:  br_alu_op = 4'b1000;
            3'b101:  br_alu_op = 4'b1011;
            default: br_alu_op = 4'b1111;
        endcase
    endfunction

`ifdef MEM_READY_EN
    assign mem_done_s = mem_ready;
`else
    assign mem_done_s = 1'b1;
`endif

    assign is_r_s     = (opcode == OP_R);
    assign is_load_s  = (opcode == OP_LOAD);
    assign is_store_s = (opcode == OP_STORE);
    assign is_jalr_s  = (opcode == OP_JALR);

    // State register; reset returns to fetch and abandons any pending memory wait.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_IF;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        next_state_s = state_r;
        alu_op_s     = 4'b0000;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        i_or_d_s     = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        pc_write_s   = 1'b0;
        pc_source_s  = 1'b0;
        is_ecall_s   = 1'b0;
        case (state_r)
            S_IF: begin
                mem_read_s = 1'b1;
                ir_write_s = mem_done_s;
                if (mem_done_s) begin
                    next_state_s = S_ID;
                end else begin
                    next_state_s = S_IF;
                end
            end
            S_ID: begin
                alu_src_b_s = 2'b10;
                case (opcode)
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_JALR: next_state_s = S_EX;
                    OP_BR:    next_state_s = S_BR;
                    OP_JAL:   next_state_s = S_JAL;
                    OP_ECALL: begin
                        is_ecall_s   = 1'b1;
                        next_state_s = S_PC4;
                    end
                    default:  next_state_s = S_PC4;
                endcase
            end
            S_EX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = is_r_s ? 2'b00 : 2'b10;
                // Address and link-target computations always use add.
                if (is_load_s || is_store_s || is_jalr_s) begin
                    alu_op_s = 4'b0000;
                end else begin
                    alu_op_s = ex_alu_op(funct3, is_r_s & funct7_5);
                end
                if (is_load_s || is_store_s) begin
                    next_state_s = S_MEM;
                end else if (is_jalr_s) begin
                    next_state_s = S_JR;
                end else begin
                    next_state_s = S_WB;
                end
            end
            S_MEM: begin
                i_or_d_s    = 1'b1;
                mem_read_s  = is_load_s;
                mem_write_s = is_store_s;
                if (!mem_done_s) begin
                    next_state_s = S_MEM;
                end else if (is_load_s) begin
                    next_state_s = S_WB;
                end else begin
                    next_state_s = S_PC4;
                end
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = is_load_s;
                next_state_s = S_PC4;
            end
            S_PC4: begin
                alu_src_b_s  = 2'b01;
                pc_write_s   = 1'b1;
                next_state_s = S_IF;
            end
            S_BR: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = br_alu_op(funct3);
                pc_write_s  = alu_bcond;
                pc_source_s = 1'b1;
                if (alu_bcond) begin
                    next_state_s = S_IF;
                end else begin
                    next_state_s = S_PC4;
                end
            end
            S_JAL, S_JR: begin
                alu_src_b_s  = 2'b01;
                reg_write_s  = 1'b1;
                pc_write_s   = 1'b1;
                pc_source_s  = 1'b1;
                next_state_s = S_IF;
            end
            default: begin
                next_state_s = S_IF;
            end
        endcase
    end

    // Every output reads zero while reset is held low.
    assign alu_op     = reset_n ? alu_op_s     : 4'b0000;
    assign alu_src_a  = reset_n ? alu_src_a_s  : 1'b0;
    assign alu_src_b  = reset_n ? alu_src_b_s  : 2'b00;
    assign i_or_d     = reset_n ? i_or_d_s     : 1'b0;
    assign mem_read   = reset_n ? mem_read_s   : 1'b0;
    assign mem_write  = reset_n ? mem_write_s  : 1'b0;
    assign ir_write   = reset_n ? ir_write_s   : 1'b0;
    assign mem_to_reg = reset_n ? mem_to_reg_s : 1'b0;
    assign reg_write  = reset_n ? reg_write_s  : 1'b0;
    assign pc_write   = reset_n ? pc_write_s   : 1'b0;
    assign pc_source  = reset_n ? pc_source_s  : 1'b0;
    assign is_ecall   = reset_n ? is_ecall_s   : 1'b0;
    assign state      = reset_n ? state_r      : 4'd0;

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Multicycle control unit for the RV32I-subset CPU. Sequences each instruction through fetch, decode, execute, memory and writeback states. Per state, drives the datapath mux selects, memory and register-file enables, and the 4-bit `alu_op` consumed directly by the ALU stage. Consumes the ALU's `alu_bcond` to resolve branches.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  — single clock, all state updates on rising edge
- `reset_n`  in  1  — reset is synchronous and active-low
- `opcode`  in  7  — IR[6:0], held stable by the IR from ID onward
- `funct3`  in  3  — IR[14:12]
- `funct7_5`  in  1  — IR[30]
- `alu_bcond`  in  1  — branch condition from the ALU, combinational in the same cycle
- `mem_ready`  in  1  — memory handshake; exists only with `MEM_READY_EN`
- `alu_op`  out  4  — ALU operation code
- `alu_src_a`  out  1  — 0 = PC, 1 = rs1
- `alu_src_b`  out  2  — 00 = rs2, 01 = constant 4, 10 = immediate
- `i_or_d`  out  1  — memory address: 0 = PC, 1 = ALUOut
- `mem_read`, `mem_write`  out  1 each
- `ir_write`  out  1  — latch instruction register
- `mem_to_reg`  out  1  — write-back source: 0 = ALU result, 1 = MDR
- `reg_write`  out  1
- `pc_write`  out  1
- `pc_source`  out  1  — 0 = ALU result, 1 = ALUOut
- `is_ecall`  out  1  — one-cycle pulse per ECALL
- `state`  out  4  — current state, for debug

## Operation
States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, PC4=5, BR=6, JAL=7, JR=8. Unlisted outputs are 0 in every state.

- **IF:** `mem_read`=1, `i_or_d`=0, `ir_write`=1. Next state is ID.
- **ID:** `alu_src_a`=0, `alu_src_b`=10, `alu_op`=0000, so ALUOut ← PC+imm. Next state by opcode:
  - 0110011 (R-type), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100111 (JALR) → EX
  - 1100011 (branch) → BR
  - 1101111 (JAL) → JAL
  - 1110011 (ECALL) → PC4, with `is_ecall`=1 in ID
  - any other opcode → PC4 (executed as a nop)
- **EX:** `alu_src_a`=1. `alu_src_b`=00 for R-type, 10 for all others.
  - `alu_op` decoding by funct3: 000 → 0000 (add), or 0001 (sub) only when R-type and `funct7_5`=1; 001 → 1010; 100 → 1000; 101 → 1011; 110 → 0101; 111 → 0100; 010 and 011 → 0000.
  - `alu_op` is forced to 0000 for load, store and JALR.
  - Next state: load/store → MEM; JALR → JR; otherwise → WB.
- **MEM:** `i_or_d`=1. `mem_read`=1 for load, `mem_write`=1 for store. Next state: load → WB, store → PC4.
- **WB:** `reg_write`=1. `mem_to_reg`=1 for load, 0 otherwise. Next state is PC4.
- **PC4:** `alu_src_a`=0, `alu_src_b`=01, `alu_op`=0000, `pc_write`=1, `pc_source`=0 (PC ← PC+4). Next state is IF.
- **BR:** `alu_src_a`=1, `alu_src_b`=00.
  - `alu_op` by funct3: 000 → 0000, 001 → 1010, 100 → 1000, 101 → 1011, others → 1111.
  - `pc_write` = `alu_bcond` and `pc_source`=1 (Mealy output).
  - Next state: IF if `alu_bcond`=1, else PC4.
- **JAL:** `alu_src_a`=0, `alu_src_b`=01, `alu_op`=0000, `reg_write`=1, `mem_to_reg`=0 (rd ← PC+4), `pc_write`=1, `pc_source`=1. Next state is IF.
- **JR:** identical outputs to JAL; ALUOut holds rs1+imm from EX. Next state is IF.

## Timing
- `reset_n`=0 at a rising edge: state ← IF. While `reset_n`=0, all outputs are forced to 0 and `state` reads 0.
- First fetch occurs in the first cycle after `reset_n` goes high. A reset mid-instruction abandons the instruction with no further writes.
- Cycles per instruction (no wait states):
  - R-type / I-ALU: 5
  - load: 6
  - store: 5
  - branch taken: 3; branch not taken: 4
  - JAL: 3
  - JALR: 4
  - ECALL: 3
  - unknown opcode: 3
- Outputs are combinational from state and inputs. No output register stage.

## Configuration
- **`MEM_READY_EN` defined:**
  - `mem_ready` port exists.
  - IF and MEM hold their outputs and do not advance while `mem_ready`=0.
  - `ir_write` = `mem_ready` in IF.
  - Reset overrides a pending wait.
- **`MEM_READY_EN` undefined:**
  - Port is absent.
  - IF and MEM always complete in one cycle.

## Test plan
- Reset, then `reset_n`=1 with `opcode`=0110011, `funct3`=000, `funct7_5`=1 → state sequence 0,1,2,4,5,0; `alu_op`=0001 in EX; `reg_write`=1 in WB only.
- `opcode`=0010011, `funct3`=000, `funct7_5`=1 (ADDI, negative imm) → `alu_op`=0000 in EX, not 0001.
- BNE (`funct3`=001) with `alu_bcond`=1 in BR → `alu_op`=1010, `pc_write`=1, `pc_source`=1, next state 0. Same with `alu_bcond`=0 → `pc_write`=0, next state 5.
- LW then SW → load sequence 0,1,2,3,4,5 with `mem_read`=1 and `mem_to_reg`=1 in WB; store sequence 0,1,2,3,5 with `mem_write`=1 in MEM only.
- ECALL → `is_ecall`=1 for exactly one cycle, in ID. `opcode`=0000000 → sequence 0,1,5,0 with no writes.
- With `MEM_READY_EN` defined, hold `mem_ready`=0 for 3 cycles in IF → state stays 0 and `ir_write`=0; `mem_ready`=1 → `ir_write`=1 and next state 1. Assert `reset_n`=0 during MEM → all outputs 0 and state 0.
